// File: rtl/alu_ex_stage.sv
// Execute stage: holds one decoded instruction in the EX register, drives the
// external 32-bit ALU from it and registers the ALU result toward MEM.
module alu_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [15:0]      in_imm,
    input  logic             in_alu_src,
    input  logic [1:0]       in_alu_op,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_exc
);

    localparam logic [2:0] CTR_AND = 3'b000;
    localparam logic [2:0] CTR_OR  = 3'b001;
    localparam logic [2:0] CTR_ADD = 3'b010;
    localparam logic [2:0] CTR_SUB = 3'b110;
    localparam logic [2:0] CTR_SLT = 3'b111;

    logic             r_ex_valid;
    logic [WIDTH-1:0] r_ex_a;
    logic [WIDTH-1:0] r_ex_b;
    logic [15:0]      r_ex_imm;
    logic             r_ex_alu_src;
    logic [1:0]       r_ex_alu_op;
    logic [5:0]       r_ex_funct;
    logic [4:0]       r_ex_rd;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_res;
    logic             r_out_zero;
    logic [4:0]       r_out_rd;
    logic             r_out_exc;

    logic             w_out_load;
    logic             w_in_ready;
    logic             w_ex_load;
    logic [2:0]       w_alu_ctr;
    logic             w_illegal;
    logic             w_signed_op;
    logic [WIDTH-1:0] w_alu_b;
    logic             w_trap;

    // Flush blocks both the OUT load and new acceptance in the same cycle.
    assign w_out_load = r_ex_valid & (~r_out_valid | out_ready) & ~flush;
    assign w_in_ready = ~flush & (~r_ex_valid | w_out_load);
    assign w_ex_load  = in_valid & w_in_ready;
    assign w_trap     = w_illegal | (alu_ovf & w_signed_op);

    // ALU control decode and trap qualification from the held instruction.
    always_comb begin
        w_alu_ctr   = CTR_ADD;
        w_illegal   = 1'b0;
        w_signed_op = 1'b0;
        case (r_ex_alu_op)
            2'b00: w_alu_ctr = CTR_ADD;
            2'b01: w_alu_ctr = CTR_SUB;
            2'b11: w_alu_ctr = CTR_OR;
            2'b10: begin
                case (r_ex_funct)
                    6'b100000: begin
                        w_alu_ctr   = CTR_ADD;
                        w_signed_op = 1'b1;
                    end
                    6'b100001: w_alu_ctr = CTR_ADD;
                    6'b100010: begin
                        w_alu_ctr   = CTR_SUB;
                        w_signed_op = 1'b1;
                    end
                    6'b100011: w_alu_ctr = CTR_SUB;
                    6'b100100: w_alu_ctr = CTR_AND;
                    6'b100101: w_alu_ctr = CTR_OR;
                    6'b101010: w_alu_ctr = CTR_SLT;
                    default: begin
                        w_alu_ctr = CTR_ADD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: w_alu_ctr = CTR_ADD;
        endcase
    end

    // B operand select; or-immediate zero-extends, everything else sign-extends.
    always_comb begin
        w_alu_b = r_ex_b;
        if (r_ex_alu_src) begin
            if (r_ex_alu_op == 2'b11) begin
                w_alu_b = {{(WIDTH-16){1'b0}}, r_ex_imm};
            end else begin
                w_alu_b = {{(WIDTH-16){r_ex_imm[15]}}, r_ex_imm};
            end
        end else begin
            w_alu_b = r_ex_b;
        end
    end

    // EX register: captures an accepted instruction, emptied by advance or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid   <= 1'b0;
            r_ex_a       <= {WIDTH{1'b0}};
            r_ex_b       <= {WIDTH{1'b0}};
            r_ex_imm     <= 16'h0000;
            r_ex_alu_src <= 1'b0;
            r_ex_alu_op  <= 2'b00;
            r_ex_funct   <= 6'b000000;
            r_ex_rd      <= 5'd0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_ex_load) begin
            r_ex_valid   <= 1'b1;
            r_ex_a       <= in_a;
            r_ex_b       <= in_b;
            r_ex_imm     <= in_imm;
            r_ex_alu_src <= in_alu_src;
            r_ex_alu_op  <= in_alu_op;
            r_ex_funct   <= in_funct;
            r_ex_rd      <= in_rd;
        end else if (w_out_load) begin
            r_ex_valid <= 1'b0;
        end
    end

    // OUT register: takes the ALU result on advance, empties when MEM accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= {WIDTH{1'b0}};
            r_out_zero  <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_exc   <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= 1'b1;
            r_out_res   <= alu_res;
            r_out_zero  <= alu_zero;
            r_out_rd    <= r_ex_rd;
            r_out_exc   <= w_trap;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign alu_a     = r_ex_a;
    assign alu_b     = w_alu_b;
    assign alu_ctr   = w_alu_ctr;
    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_zero  = r_out_zero;
    assign out_rd    = r_out_rd;
    assign out_exc   = r_out_exc;

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute-stage wrapper for the 32-bit ALU in the multicycle/pipelined CPU.
- Accepts one decoded instruction per handshake from the ID stage and holds it in an EX register.
- From that register it derives the ALU control code and operands and drives the external combinational ALU.
- Captures the ALU's result and flags into an output register that feeds the MEM stage through valid/ready.

Parameters:
- WIDTH, 32, datapath width; the ALU is fixed at 32, so other values are unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID offers an instruction.
- in_ready  out  1  stage can accept.
- in_a  in  32  rs operand.
- in_b  in  32  rt operand.
- in_imm  in  16  immediate field.
- in_alu_src  in  1  1 = sign-extended immediate as B.
- in_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate.
- in_funct  in  6  R-type function field.
- in_rd  in  5  destination register tag.
- flush  in  1  kills the EX-register contents.
- alu_a  out  32  to ALU A.
- alu_b  out  32  to ALU B.
- alu_ctr  out  3  to ALU control.
- alu_res  in  32  from ALU.
- alu_zero  in  1  from ALU.
- alu_ovf  in  1  from ALU.
- out_valid  out  1  result available.
- out_ready  in  1  MEM accepts.
- out_res  out  32  registered result.
- out_zero  out  1  registered zero flag.
- out_rd  out  5  registered destination tag.
- out_exc  out  1  1 = overflow trap or illegal funct; result is not to be written back.

Behaviour:
- One clock domain, clk.
- rst_n is asynchronous and active-low: every register clears immediately on assertion and releases on the next clk edge after deassertion.
- Reset values: ex_valid=0, out_valid=0, out_res=0, out_zero=0, out_rd=0, out_exc=0, all EX fields 0.
- Two registers:
  - EX register: captured fields plus ex_valid.
  - OUT register: result plus out_valid.
- Combinational ALU drive from the EX register:
  - alu_a = ex_a.
  - alu_b = ex_alu_src ? {{16{imm[15]}},imm} : ex_b.
  - Exception: in_alu_op=11 zero-extends imm.
- alu_ctr decode:
  - alu_op 00 -> 010.
  - alu_op 01 -> 110.
  - alu_op 11 -> 001.
  - alu_op 10, funct 100000/100001 -> 010.
  - alu_op 10, funct 100010/100011 -> 110.
  - alu_op 10, funct 100100 -> 000.
  - alu_op 10, funct 100101 -> 001.
  - alu_op 10, funct 101010 -> 111.
  - Any other funct -> 010 with illegal=1.
  - alu_ctr never takes 011, 100 or 101.
- Trap: trap = illegal OR (alu_ovf AND signed op). Signed op means alu_op=10 with funct 100000/100010.
  - alu_op 00/01 ignore overflow.
- Pipeline advance:
  - out_load = ex_valid AND (!out_valid OR out_ready).
  - in_ready = !ex_valid OR out_load. This is combinational from out_ready; no skid buffer.
  - EX register loads when in_valid AND in_ready.
  - If out_load and no new input: ex_valid clears.
  - OUT register loads on out_load: out_res=alu_res, out_zero=alu_zero, out_rd=ex_rd, out_exc=trap, out_valid=1.
  - If out_valid AND out_ready AND !out_load: out_valid clears.
- Latency: one instruction accepted at edge N appears at out_valid at edge N+1 when unstalled. Throughput is one per cycle.
- Backpressure:
  - With out_ready=0 and out_valid=1, the OUT register holds.
  - The EX register holds one further op; in_ready=0 until the OUT register drains.
  - alu_* outputs stay stable while stalled.
- flush:
  - Clears ex_valid at the edge regardless of stall, and suppresses out_load that cycle.
  - in_ready is forced 0 during flush, so an instruction offered in the same cycle is dropped (not accepted).
  - The OUT register is unaffected; already-completed results still deliver.
- Reset mid-transfer: both valids drop immediately and no partial handshake completes.

Test Plan:
- Add: in_a=5, in_b=7, alu_op=10, funct=100000 -> alu_ctr=010; next cycle out_valid=1, out_res=12, out_zero=0, out_exc=0.
- Overflow: in_a=0x7FFFFFFF, in_b=1, funct=100000 with ALU returning ovf=1 -> out_exc=1. Same operands with funct=100001 -> out_exc=0.
- Illegal funct: alu_op=10, funct=000111 -> alu_ctr=010 and out_exc=1.
- Immediate: alu_src=1, imm=0xFFFF, alu_op=00 -> alu_b=0xFFFFFFFF. Same with alu_op=11 -> alu_b=0x0000FFFF, alu_ctr=001.
- Backpressure: stream 3 ops with out_ready=0 -> accepts 2, in_ready=0 from the third cycle. Release out_ready -> results delivered in order, no loss or duplication.
- Flush/reset: flush while ex_valid=1 and out_ready=0 -> EX op discarded, OUT result retained. Assert rst_n=0 asynchronously mid-stream -> out_valid=0 and in_ready=1 before the next edge.
